// File: rtl/hbridge_pkg.sv
// Shared constants for the H-bridge PWM driver: direction codes, FSM encoding
// and the illegal-code predicate.
package hbridge_pkg;

    localparam logic [3:0] DIR_STOP  = 4'b0000;
    localparam logic [3:0] DIR_LEFT  = 4'b0101;
    localparam logic [3:0] DIR_FWD   = 4'b0110;
    localparam logic [3:0] DIR_RIGHT = 4'b1010;
    localparam logic [3:0] DIR_BACK  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_BRAKE = 2'b10
    } state_t;

    // Both switches of one half-bridge on would short the supply.
    function automatic logic is_illegal_code(input logic [3:0] code);
        return (code[3] & code[2]) | (code[1] & code[0]);
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter: cnt runs 0..PERIOD-1 and boundary marks
// the last cycle of each period.
module pwm_period_counter
    import hbridge_pkg::*;
#(
    parameter int PERIOD = 50000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] cnt,
    output logic        boundary
);

    localparam logic [15:0] LAST = 16'(PERIOD - 1);

    assign boundary = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/hbridge_pwm_driver.sv
// H-bridge PWM driver with brake interval on direction reversal.
// Optional soft start ramp compiled in with macro HBRIDGE_SOFTSTART_EN.
module hbridge_pwm_driver
    import hbridge_pkg::*;
#(
    parameter int PERIOD    = 50000,
    parameter int DEADTIME  = 100000,
    parameter int RAMP_STEP = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  direction,
    input  logic [15:0] widthChassis,
    output logic [3:0]  hbridge,
    output logic        ena,
    output logic        enb,
    output logic [1:0]  state,
    output logic        illegal
);

    localparam logic [19:0] DT_LAST = 20'(DEADTIME);

    logic [15:0] cnt;
    logic        boundary;

    state_t      fsm, fsm_nxt;
    logic [3:0]  code_act, code_nxt;
    logic [15:0] duty_act, duty_nxt;
    logic [19:0] dt_cnt, dt_nxt;
    logic [3:0]  code_smp;
    logic        req_drive;
    logic        ena_nxt;

`ifdef HBRIDGE_SOFTSTART_EN
    // Ramp up by RAMP_STEP toward target; a lower target applies immediately.
    function automatic logic [15:0] ramp_duty(input logic [15:0] cur,
                                              input logic [15:0] target);
        logic [16:0] sum;
        sum = {1'b0, cur} + 17'(RAMP_STEP);
        if (target <= cur) begin
            return target;
        end else if (sum >= {1'b0, target}) begin
            return target;
        end else begin
            return sum[15:0];
        end
    endfunction
`endif

    pwm_period_counter #(
        .PERIOD(PERIOD)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .cnt     (cnt),
        .boundary(boundary)
    );

    assign code_smp  = is_illegal_code(direction) ? DIR_STOP : direction;
    assign req_drive = (code_smp != DIR_STOP) && (widthChassis != 16'd0);

    always_comb begin
        fsm_nxt  = fsm;
        code_nxt = code_act;
        duty_nxt = duty_act;
        dt_nxt   = dt_cnt;
        case (fsm)
            ST_IDLE: begin
                if (boundary && req_drive) begin
                    fsm_nxt  = ST_DRIVE;
                    code_nxt = code_smp;
                end
            end
            ST_DRIVE: begin
                if (boundary) begin
                    if (!req_drive) begin
                        fsm_nxt  = ST_IDLE;
                        code_nxt = DIR_STOP;
                    end else if (code_smp != code_act) begin
                        fsm_nxt  = ST_BRAKE;
                        code_nxt = DIR_STOP;
                        dt_nxt   = '0;
                    end
                end
            end
            ST_BRAKE: begin
                // The dead-time count ignores request changes; only the exit sample matters.
                if (dt_cnt != DT_LAST) begin
                    dt_nxt = dt_cnt + 20'd1;
                end
                if (boundary && (dt_cnt == DT_LAST)) begin
                    fsm_nxt  = req_drive ? ST_DRIVE : ST_IDLE;
                    code_nxt = req_drive ? code_smp : DIR_STOP;
                end
            end
            default: begin
                fsm_nxt  = ST_IDLE;
                code_nxt = DIR_STOP;
            end
        endcase

        if (boundary) begin
`ifdef HBRIDGE_SOFTSTART_EN
            duty_nxt = (fsm_nxt == ST_DRIVE) ? ramp_duty(duty_act, widthChassis) : 16'd0;
`else
            duty_nxt = widthChassis;
`endif
        end

        // Blank the enable on the edge that leaves DRIVE so it never outlives the code.
        ena_nxt = (fsm == ST_DRIVE) && (fsm_nxt == ST_DRIVE) && (cnt < duty_act);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm      <= ST_IDLE;
            code_act <= DIR_STOP;
            duty_act <= '0;
            dt_cnt   <= '0;
            hbridge  <= DIR_STOP;
            ena      <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            fsm      <= fsm_nxt;
            code_act <= code_nxt;
            duty_act <= duty_nxt;
            dt_cnt   <= dt_nxt;
            hbridge  <= (fsm_nxt == ST_DRIVE) ? code_nxt : DIR_STOP;
            ena      <= ena_nxt;
            illegal  <= boundary && is_illegal_code(direction);
        end
    end

    assign enb   = ena;
    assign state = fsm;

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// Directed table-driven bench for hbridge_pwm_driver (PERIOD=100, DEADTIME=20, RAMP_STEP=25).
module tb_hbridge_pwm_driver;
    import hbridge_pkg::*;

    localparam int P  = 100;
    localparam int DT = 20;
    localparam int RS = 25;
`ifdef HBRIDGE_SOFTSTART_EN
    localparam int SETTLE = 8;
`else
    localparam int SETTLE = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  direction = 4'b0000;
    logic [15:0] widthChassis = 16'd0;
    logic [3:0]  hbridge;
    logic        ena;
    logic        enb;
    logic [1:0]  state;
    logic        illegal;

    int checks = 0;
    int failures = 0;
    int ph = 0;

    typedef struct {
        logic [3:0]  dir;
        logic [15:0] width;
        logic [3:0]  hb;
        logic [1:0]  st;
        logic        ill;
        int          ena_n;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    hbridge_pwm_driver #(
        .PERIOD   (P),
        .DEADTIME (DT),
        .RAMP_STEP(RS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .direction   (direction),
        .widthChassis(widthChassis),
        .hbridge     (hbridge),
        .ena         (ena),
        .enb         (enb),
        .state       (state),
        .illegal     (illegal)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ph tracks the DUT counter value visible 1 time unit after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
        ph = (ph == P - 1) ? 0 : ph + 1;
    endtask

    task automatic next_period();
        tick();
        while (ph != 0) tick();
    endtask

    task automatic goto_phase(input int p);
        while (ph != p) tick();
    endtask

    task automatic measure(input logic [3:0] exp_hb, output int n_ena,
                           output int n_hb_bad, output int n_enb_bad);
        n_ena = 0;
        n_hb_bad = 0;
        n_enb_bad = 0;
        for (int k = 0; k < P; k++) begin
            if (ena) n_ena++;
            if (hbridge != exp_hb) n_hb_bad++;
            if (enb != ena) n_enb_bad++;
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ena, n_hb_bad, n_enb_bad;
        logic [3:0] prev;
        int brake_len, viol, found, saw_brake, found_ph;

        tbl[0] = '{DIR_FWD,   16'd40,  DIR_FWD,   2'b01, 1'b0, 40};
        tbl[1] = '{DIR_FWD,   16'd70,  DIR_FWD,   2'b01, 1'b0, 70};
        tbl[2] = '{DIR_STOP,  16'd70,  DIR_STOP,  2'b00, 1'b0, 0};
        tbl[3] = '{4'b0011,   16'd40,  DIR_STOP,  2'b00, 1'b1, 0};
        tbl[4] = '{DIR_LEFT,  16'd150, DIR_LEFT,  2'b01, 1'b0, 100};
        tbl[5] = '{DIR_LEFT,  16'd0,   DIR_STOP,  2'b00, 1'b0, 0};
        tbl[6] = '{4'b1100,   16'd50,  DIR_STOP,  2'b00, 1'b1, 0};
        tbl[7] = '{DIR_RIGHT, 16'd100, DIR_RIGHT, 2'b01, 1'b0, 100};
        tbl[8] = '{DIR_RIGHT, 16'd99,  DIR_RIGHT, 2'b01, 1'b0, 99};
        tbl[9] = '{DIR_STOP,  16'd0,   DIR_STOP,  2'b00, 1'b0, 0};

        reset = 1'b1;
        tick();
        tick();
        ph = 0;
        check("reset_hbridge", int'(hbridge), 0);
        check("reset_ena", int'(ena), 0);
        check("reset_enb", int'(enb), 0);
        check("reset_state", int'(state), 0);
        check("reset_illegal", int'(illegal), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            direction = tbl[i].dir;
            widthChassis = tbl[i].width;
            next_period();
            check($sformatf("v%0d_illegal_pulse", i), int'(illegal), int'(tbl[i].ill));
            check($sformatf("v%0d_hbridge", i), int'(hbridge), int'(tbl[i].hb));
            check($sformatf("v%0d_state", i), int'(state), int'(tbl[i].st));
            tick();
            check($sformatf("v%0d_illegal_end", i), int'(illegal), 0);
            repeat (SETTLE) next_period();
            measure(tbl[i].hb, n_ena, n_hb_bad, n_enb_bad);
            check($sformatf("v%0d_ena_count", i), n_ena, tbl[i].ena_n);
            check($sformatf("v%0d_hbridge_stable", i), n_hb_bad, 0);
            check($sformatf("v%0d_enb_eq_ena", i), n_enb_bad, 0);
        end

        // Reversal FWD -> BACK must pass through a full brake period.
        direction = DIR_FWD;
        widthChassis = 16'd40;
        next_period();
        check("rev_start_hbridge", int'(hbridge), int'(DIR_FWD));
        direction = DIR_BACK;
        prev = hbridge;
        brake_len = 0;
        viol = 0;
        found = 0;
        saw_brake = 0;
        found_ph = -1;
        for (int k = 0; k < 400 && found == 0; k++) begin
            tick();
            if (prev != DIR_STOP && hbridge != DIR_STOP && prev != hbridge) viol++;
            if (hbridge == DIR_BACK) begin
                found = 1;
                found_ph = ph;
            end else if (hbridge == DIR_STOP && !ena) begin
                brake_len++;
            end
            if (state == 2'b10) saw_brake = 1;
            prev = hbridge;
        end
        check("rev_reached_back", found, 1);
        check("rev_direct_switch", viol, 0);
        check("rev_brake_len", brake_len, P);
        check("rev_saw_brake_state", saw_brake, 1);
        check("rev_back_phase", found_ph, 0);
        check("rev_back_state", int'(state), 1);

        // Request changes during brake do not restart the dead-time count.
        direction = DIR_RIGHT;
        next_period();
        check("brk_chg_state", int'(state), 2);
        goto_phase(15);
        direction = DIR_STOP;
        goto_phase(90);
        direction = DIR_LEFT;
        widthChassis = 16'd60;
        next_period();
        check("brk_chg_exit_hbridge", int'(hbridge), int'(DIR_LEFT));
        check("brk_chg_exit_state", int'(state), 1);

        // Reset in the middle of a brake interval.
        direction = DIR_RIGHT;
        widthChassis = 16'd40;
        next_period();
        check("rst_brk_state_before", int'(state), 2);
        goto_phase(10);
        reset = 1'b1;
        tick();
        ph = 0;
        check("rst_brk_hbridge", int'(hbridge), 0);
        check("rst_brk_ena", int'(ena), 0);
        check("rst_brk_enb", int'(enb), 0);
        check("rst_brk_state", int'(state), 0);
        check("rst_brk_illegal", int'(illegal), 0);
        reset = 1'b0;
        goto_phase(99);
        check("rst_idle_hbridge", int'(hbridge), 0);
        check("rst_idle_state", int'(state), 0);
        next_period();
        check("rst_restart_hbridge", int'(hbridge), int'(DIR_RIGHT));
        check("rst_restart_state", int'(state), 1);

`ifdef HBRIDGE_SOFTSTART_EN
        direction = DIR_STOP;
        next_period();
        direction = DIR_FWD;
        widthChassis = 16'd80;
        next_period();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) widthChassis = 16'd30;
            measure(DIR_FWD, n_ena, n_hb_bad, n_enb_bad);
            check($sformatf("ramp_p%0d_ena_count", k), n_ena, (k == 3) ? 80 : RS * (k + 1));
        end
        measure(DIR_FWD, n_ena, n_hb_bad, n_enb_bad);
        check("ramp_lower_ena_count", n_ena, 30);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hbridge_pwm_driver.md
HBRIDGE_PWM_DRIVER -- requirements
Module: hbridge_pwm_driver

Interface
REQ-001 Parameter PERIOD, default 50000, PWM period in clk cycles (2..65535).
REQ-002 Parameter DEADTIME, default 100000, brake interval in clk cycles on direction reversal (1..2^20-1).
REQ-003 Parameter RAMP_STEP, default 1000, duty increment per period when soft start is compiled in.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 direction  in  4  requested H-bridge code {in1,in2,in3,in4} from the navigation block.
REQ-007 widthChassis  in  16  requested duty in clk cycles high per period.
REQ-008 hbridge  out  4  registered H-bridge input pins.
REQ-009 ena  out  1  PWM enable, motor A; enb  out  1  PWM enable, motor B (identical waveform).
REQ-010 state  out  2  current FSM state (debug LEDs).
REQ-011 illegal  out  1  high for one cycle when an illegal code is sampled.

Function
REQ-012 Free-running counter cnt runs 0..PERIOD-1 and wraps to 0; the boundary is cnt==PERIOD-1.
REQ-013 direction and widthChassis are sampled only at the boundary; new values take effect at cnt==0 of the next period.
REQ-014 A code with in1&in2 or in3&in4 both high is illegal: treat as 0000 and pulse illegal on the sampling cycle.
REQ-015 FSM states: IDLE(00), DRIVE(01), BRAKE(10).
REQ-016 IDLE: hbridge=0000, ena=enb=0; at a boundary with sampled code!=0000 and width!=0, go to DRIVE with that code.
REQ-017 DRIVE: hbridge=active code, ena=enb=(cnt<duty_active), registered, 1-cycle latency from cnt.
REQ-018 DRIVE, boundary, sampled code==0000 or width==0: go to IDLE with no dead time.
REQ-019 DRIVE, boundary, sampled nonzero code!=active code: go to BRAKE; hbridge=0000, ena=enb=0.
REQ-020 DRIVE, same code and new width: update duty only, no interruption.
REQ-021 BRAKE counts DEADTIME cycles, then waits for the next boundary and moves to DRIVE/IDLE using the code sampled at that boundary.
REQ-022 Requests changing during BRAKE do not restart the dead-time counter; only the sample at the exit boundary is used.
REQ-023 A width >= PERIOD gives 100% duty (ena=enb constantly high in DRIVE).
REQ-024 Outputs never go from one nonzero code directly to a different nonzero code.

Reset
REQ-025 While reset is high at a clk edge: cnt=0, state=IDLE, hbridge=0000, ena=enb=0, illegal=0, duty_active=0, dead-time counter=0.
REQ-026 A reset in any state, including mid-BRAKE, forces these values at the next edge; after release, operation restarts from IDLE at cnt=0.

Configuration
REQ-027 Macro HBRIDGE_SOFTSTART_EN defined: on each boundary in DRIVE, duty_active rises by RAMP_STEP, saturating at the target.
REQ-028 With the macro, a lower target applies at once, and duty_active clears to 0 on entry to IDLE or BRAKE.
REQ-029 Macro undefined: duty_active equals the sampled width at the boundary; no ramp logic is synthesized.

Structure
REQ-030 Shared package hbridge_pkg holds the direction constants DIR_STOP=0000, DIR_LEFT=0101, DIR_FWD=0110, DIR_RIGHT=1010, DIR_BACK=1001, plus the state encoding.
REQ-031 One sub-module, pwm_period_counter, provides cnt and a boundary strobe.

Verification (bench: PERIOD=100, DEADTIME=20, RAMP_STEP=25)
REQ-032 IDLE, DIR_FWD, width 40 -> hbridge=0110 from the next cnt==0; ena high 40 of each 100 cycles (macro off).
REQ-033 DRIVE FWD, switch to DIR_BACK -> 0000 and ena=0 for at least 20 cycles until the next boundary, then 1001; never 0110->1001 directly.
REQ-034 Code 0011 sampled -> illegal pulses 1 cycle; state IDLE; hbridge=0000.
REQ-035 width 150 with DIR_LEFT -> ena constantly high; hbridge=0101.
REQ-036 Reset asserted mid-BRAKE -> all outputs 0 and state=00 at the next edge.
REQ-037 Macro on, DIR_FWD, width 80 -> duty 25, 50, 75, 80 over four periods; then width 30 -> duty 30 in the next period.
